// File: rtl/echo_capture.sv
// echo_capture: times an ultrasonic echo pulse in microseconds and centimetres after each arm
module echo_capture #(
   parameter int TICKS_PER_MICRO = 100,
   parameter int US_PER_CM       = 58,
   parameter int MAX_US          = 60000,
   parameter int US_W            = 16,
   parameter int CM_W            = 11
) (
   input  logic            PCLK,
   input  logic            reset,
   input  logic            arm,
   input  logic            echo,
   output logic            busy,
   output logic            valid,
   output logic            timeout,
   output logic [US_W-1:0] echo_us,
   output logic [CM_W-1:0] dist_cm
);
   localparam int PW = TICKS_PER_MICRO > 1 ? $clog2(TICKS_PER_MICRO) : 1;
   localparam int SW = US_PER_CM > 1 ? $clog2(US_PER_CM) : 1;
   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;
   state_t state, state_n;
   logic echo_m, echo_s, echo_d, rise, fall;
   logic [PW-1:0] pre;
   logic [US_W-1:0] us_cnt;
   logic [SW-1:0] cm_sub;
   logic [CM_W-1:0] cm_cnt;
   logic wrap, cm_wrap, expire, clr, valid_n, timeout_n;
   assign rise    = echo_s & ~echo_d;
   assign fall    = ~echo_s & echo_d;
   assign wrap    = pre == PW'(TICKS_PER_MICRO - 1);
   assign cm_wrap = cm_sub == SW'(US_PER_CM - 1);
   assign expire  = wrap && us_cnt == US_W'(MAX_US - 1);
   assign busy    = state != IDLE;
   // two-flop synchroniser for the asynchronous echo pin, plus one delay stage for edge detection
   always_ff @(posedge PCLK) begin
      if (reset) {echo_m, echo_s, echo_d} <= '0;
      else {echo_m, echo_s, echo_d} <= {echo, echo_m, echo_s};
   end
   // next state and result strobes; a fall beats a simultaneous expiry
   always_comb begin
      state_n   = state;
      valid_n   = 1'b0;
      timeout_n = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE:      if (arm) begin state_n = WAIT_RISE; clr = 1'b1; end
         WAIT_RISE: if (rise) begin state_n = MEASURE; clr = 1'b1; end
                    else if (expire) begin state_n = IDLE; timeout_n = 1'b1; end
         MEASURE:   if (fall) begin state_n = IDLE; valid_n = 1'b1; end
                    else if (expire) begin state_n = IDLE; timeout_n = 1'b1; end
         default:   state_n = IDLE;
      endcase
   end
   // state register, registered strobes, and result capture on a good fall only
   always_ff @(posedge PCLK) begin
      if (reset) begin
         state   <= IDLE;
         valid   <= 1'b0;
         timeout <= 1'b0;
         echo_us <= '0;
         dist_cm <= '0;
      end else begin
         state   <= state_n;
         valid   <= valid_n;
         timeout <= timeout_n;
         if (valid_n) begin
            echo_us <= us_cnt;
            dist_cm <= cm_cnt;
         end
      end
   end
   // prescaled microsecond counter; centimetres are divided out by a second counter while measuring
   always_ff @(posedge PCLK) begin
      if (reset || clr) begin
         pre    <= '0;
         us_cnt <= '0;
         cm_sub <= '0;
         cm_cnt <= '0;
      end else if (busy) begin
         pre <= wrap ? '0 : pre + 1'b1;
         if (wrap) us_cnt <= us_cnt + 1'b1;
         if (wrap && state == MEASURE) begin
            cm_sub <= cm_wrap ? '0 : cm_sub + 1'b1;
            cm_cnt <= cm_cnt + CM_W'(cm_wrap);
         end
      end
   end
endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: scoreboard bench for echo_capture with a scaled-down prescaler and timeout
module tb_echo_capture;
   localparam int T  = 4;
   localparam int U  = 3;
   localparam int MX = 1000;
   typedef struct {bit to; int us; int cm; longint cyc;} exp_t;
   logic PCLK = 1'b0, reset = 1'b1, arm = 1'b0, echo = 1'b0;
   logic busy, valid, timeout;
   logic [15:0] echo_us;
   logic [10:0] dist_cm;
   exp_t q[$];
   int total = 0, bad = 0, m_us = 0, m_cm = 0;
   longint cyc = 0;
   echo_capture #(.TICKS_PER_MICRO(T), .US_PER_CM(U), .MAX_US(MX), .US_W(16), .CM_W(11)) dut (
      .PCLK(PCLK), .reset(reset), .arm(arm), .echo(echo), .busy(busy), .valid(valid),
      .timeout(timeout), .echo_us(echo_us), .dist_cm(dist_cm));
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;
   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // pop the oldest expectation whenever the DUT reports a result
   always @(negedge PCLK) begin
      if (valid || timeout) begin
         if (q.size() == 0) chk("spurious", {valid, timeout}, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("is_timeout", timeout, e.to);
            chk("exclusive", valid & timeout, 0);
            chk("busy_done", busy, 0);
            chk("echo_us", echo_us, e.us);
            chk("dist_cm", dist_cm, e.cm);
            if (e.cyc != 0) chk("to_cycle", cyc, e.cyc);
         end
      end
   end
   task automatic wait_drain(input int lim);
      int n = 0;
      while (q.size() != 0 && n < lim) begin
         @(negedge PCLK);
         n++;
      end
      chk("drain", q.size(), 0);
      repeat (10) @(negedge PCLK);
   endtask
   task automatic run_pulse(input int gap, input int h, input bit to_exp, input bit pre_high,
                            input bit arm_mid, input bit arm_end);
      if (pre_high) begin
         echo = 1'b1;
         repeat (10) @(negedge PCLK);
      end
      arm = 1'b1;
      @(negedge PCLK);
      arm = 1'b0;
      if (pre_high) begin
         repeat (20) @(negedge PCLK);
         chk("wait_rise_busy", busy, 1);
         echo = 1'b0;
      end
      repeat (gap + 1) @(negedge PCLK);
      echo = 1'b1;
      if (!to_exp) begin
         m_us = (h - 1) / T;
         m_cm = m_us / U;
      end
      q.push_back('{to_exp, m_us, m_cm, 0});
      for (int i = 0; i < h; i++) begin
         arm = arm_mid && i == h / 2;
         @(negedge PCLK);
      end
      arm  = 1'b0;
      echo = 1'b0;
      if (arm_end) begin
         repeat (2) @(negedge PCLK);
         arm = 1'b1;
         @(negedge PCLK);
         arm = 1'b0;
         chk("arm_on_valid", busy, 0);
      end
      wait_drain(MX * T + 100);
   endtask
   initial begin
      repeat (3) @(negedge PCLK);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_us", echo_us, 0);
      chk("rst_cm", dist_cm, 0);
      reset = 1'b0;
      @(negedge PCLK);
      run_pulse(80, 2320, 0, 0, 0, 1);
      arm = 1'b1;
      q.push_back('{1, m_us, m_cm, cyc + 1 + MX * T});
      @(negedge PCLK);
      arm = 1'b0;
      chk("armed_busy", busy, 1);
      wait_drain(MX * T + 100);
      run_pulse(5, MX * T, 0, 0, 0, 0);
      run_pulse(5, MX * T + 1, 1, 0, 0, 0);
      run_pulse(5, 2400, 0, 1, 1, 0);
      arm = 1'b1;
      @(negedge PCLK);
      arm = 1'b0;
      repeat (10) @(negedge PCLK);
      echo = 1'b1;
      repeat (1200) @(negedge PCLK);
      reset = 1'b1;
      @(negedge PCLK);
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_us", echo_us, 0);
      chk("mid_rst_cm", dist_cm, 0);
      m_us = 0;
      m_cm = 0;
      echo = 1'b0;
      repeat (20) @(negedge PCLK);
      run_pulse(3, 35, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++)
         run_pulse(int'($urandom_range(0, 20)), int'($urandom_range(35, 400)), 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      repeat (80000) @(posedge PCLK);
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
